// File: rtl/video_timing_sequencer.sv
// Raster timing generator for one fixed video mode: pixel enable, h/v counters, syncs, blanks, DE.
// Scanout starts and stops only on frame boundaries; en is sampled on pixel-enable edges only.
module video_timing_sequencer #(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 192,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 58
) (
  input  logic       clk_vid,
  input  logic       reset_n,
  input  logic       en,
  output logic       ce_pix,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank,
  output logic       DE,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_BLK  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_BLK  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_div;
  logic       r_ce;
  logic [9:0] r_h, r_v;
  logic       r_hs, r_vs, r_hb, r_vb, r_de, r_fs;

  logic [9:0] w_h_nxt, w_v_nxt;
  logic       w_eol, w_eof, w_fs_nxt, w_idle_nxt;
  logic       w_hs, w_vs, w_hb, w_vb;

  always_comb begin
    w_eol       = (r_h == H_LAST);
    w_eof       = w_eol && (r_v == V_LAST);
    w_state_nxt = r_state;
    w_h_nxt     = w_eol ? 10'd0 : r_h + 10'd1;
    w_v_nxt     = w_eol ? ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1) : r_v;
    w_fs_nxt    = w_eof;
    case (r_state)
      S_IDLE: begin
        w_h_nxt  = 10'd0;
        w_v_nxt  = 10'd0;
        w_fs_nxt = en;
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // A re-arm on the last pixel keeps scanning rather than stopping.
        if (en) begin
          w_state_nxt = S_RUN;
        end else if (w_eof) begin
          w_state_nxt = S_IDLE;
          w_fs_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_h_nxt     = 10'd0;
        w_v_nxt     = 10'd0;
        w_fs_nxt    = 1'b0;
      end
    endcase

    w_idle_nxt = (w_state_nxt == S_IDLE);
    w_hb = w_idle_nxt || (w_h_nxt >= H_BLK);
    w_vb = w_idle_nxt || (w_v_nxt >= V_BLK);
    w_hs = !w_idle_nxt && (w_h_nxt >= H_SS) && (w_h_nxt < H_SE);
    w_vs = !w_idle_nxt && (w_v_nxt >= V_SS) && (w_v_nxt < V_SE);
  end

  always_ff @(posedge clk_vid) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (r_ce) begin
      r_state <= w_state_nxt;
    end
  end

  // Decode is computed from next-counter values so it lands on the same edge as the counters.
  always_ff @(posedge clk_vid) begin
    if (!reset_n) begin
      r_div <= 4'd0;
      r_ce  <= 1'b0;
      r_fs  <= 1'b0;
      r_h   <= 10'd0;
      r_v   <= 10'd0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_hb  <= 1'b1;
      r_vb  <= 1'b1;
      r_de  <= 1'b0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
      r_ce  <= (r_div == DIV_LAST);
      r_fs  <= r_ce && w_fs_nxt;
      if (r_ce) begin
        r_h  <= w_h_nxt;
        r_v  <= w_v_nxt;
        r_hs <= w_hs;
        r_vs <= w_vs;
        r_hb <= w_hb;
        r_vb <= w_vb;
        r_de <= !w_hb && !w_vb;
      end
    end
  end

  assign ce_pix      = r_ce;
  assign hcount      = r_h;
  assign vcount      = r_v;
  assign HSync       = r_hs;
  assign VSync       = r_vs;
  assign HBlank      = r_hb;
  assign VBlank      = r_vb;
  assign DE          = r_de;
  assign frame_start = r_fs;
  assign running     = (r_state != S_IDLE);

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Directed bench for video_timing_sequencer using a reduced mode (16x12 raster, CE_DIV 3).
module tb_video_timing_sequencer;

  localparam int CE = 3;
  localparam int HT = 16;
  localparam int VT = 12;
  localparam int FRAME_CLK = HT * VT * CE; // 576

  logic       clk_vid = 1'b0;
  logic       reset_n;
  logic       en;
  logic       ce_pix;
  logic [9:0] hcount, vcount;
  logic       HSync, VSync, HBlank, VBlank, DE, frame_start, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_cnt = 0, fs_last = 0, fs_prev = 0;
  int run_drops = 0;
  logic mon_run = 1'b0;

  video_timing_sequencer #(
    .CE_DIV(CE), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .en(en), .ce_pix(ce_pix),
    .hcount(hcount), .vcount(vcount), .HSync(HSync), .VSync(VSync),
    .HBlank(HBlank), .VBlank(VBlank), .DE(DE), .frame_start(frame_start),
    .running(running)
  );

  always #5 clk_vid = ~clk_vid;

  always @(posedge clk_vid) cyc <= cyc + 1;

  always @(negedge clk_vid) begin
    if (frame_start === 1'b1) begin
      fs_prev <= fs_last;
      fs_last <= cyc;
      fs_cnt  <= fs_cnt + 1;
    end
    if (mon_run && running !== 1'b1) run_drops <= run_drops + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_vid);
    #1;
  endtask

  // Advance past the next ce edge; lands #1 after the edge that updates the counters.
  task automatic next_pix();
    int k;
    k = 0;
    while (ce_pix !== 1'b1 && k < 4 * CE) begin
      tick();
      k++;
    end
    if (ce_pix !== 1'b1) check("ce_timeout", {31'd0, ce_pix}, 32'd1);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"}, {31'd0, ce_pix}, 32'd0);
    check({tag, "_h"}, {22'd0, hcount}, 32'd0);
    check({tag, "_v"}, {22'd0, vcount}, 32'd0);
    check({tag, "_hs"}, {31'd0, HSync}, 32'd0);
    check({tag, "_vs"}, {31'd0, VSync}, 32'd0);
    check({tag, "_hb"}, {31'd0, HBlank}, 32'd1);
    check({tag, "_vb"}, {31'd0, VBlank}, 32'd1);
    check({tag, "_de"}, {31'd0, DE}, 32'd0);
    check({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
    check({tag, "_run"}, {31'd0, running}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    reset_n = 1'b0;
    en      = 1'b0;
    tick(3);
    check_reset_vals("reset");

    // First ce_pix on the CE-th clock after release, then every CE clocks while idle.
    reset_n = 1'b1;
    tick(2);
    check("first_ce_early", {31'd0, ce_pix}, 32'd0);
    tick();
    check("first_ce", {31'd0, ce_pix}, 32'd1);
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("idle_ce_period", {31'd0, ce_pix}, (i % CE == 0) ? 32'd1 : 32'd0);
    end
    check("idle_h", {22'd0, hcount}, 32'd0);
    check("idle_v", {22'd0, vcount}, 32'd0);
    check("idle_hb", {31'd0, HBlank}, 32'd1);
    check("idle_vb", {31'd0, VBlank}, 32'd1);
    check("idle_de", {31'd0, DE}, 32'd0);
    check("idle_run", {31'd0, running}, 32'd0);
    check("idle_no_fs", fs_cnt, 32'd0);

    // ce_pix is high now, so the next edge starts the frame.
    en = 1'b1;
    tick();
    check("start_fs", {31'd0, frame_start}, 32'd1);
    check("start_run", {31'd0, running}, 32'd1);

    t0 = cyc;
    for (int p = 0; p < HT; p++) begin
      check("line_h", {22'd0, hcount}, p);
      check("line_v", {22'd0, vcount}, 32'd0);
      check("line_de", {31'd0, DE}, (p < 8) ? 32'd1 : 32'd0);
      check("line_hb", {31'd0, HBlank}, (p >= 8) ? 32'd1 : 32'd0);
      check("line_hs", {31'd0, HSync}, (p >= 10 && p <= 12) ? 32'd1 : 32'd0);
      next_pix();
    end
    check("line_period", cyc - t0, HT * CE);
    check("line_wrap_h", {22'd0, hcount}, 32'd0);

    for (int l = 1; l < VT; l++) begin
      check("frame_v", {22'd0, vcount}, l);
      check("frame_vb", {31'd0, VBlank}, (l >= 6) ? 32'd1 : 32'd0);
      check("frame_vs", {31'd0, VSync}, (l == 7 || l == 8) ? 32'd1 : 32'd0);
      check("frame_de", {31'd0, DE}, (l < 6) ? 32'd1 : 32'd0);
      repeat (HT) next_pix();
    end
    check("wrap_fs", {31'd0, frame_start}, 32'd1);
    check("wrap_v", {22'd0, vcount}, 32'd0);

    // Drain: drop en at line 4; the frame must complete, then go idle.
    repeat (4 * HT) next_pix();
    check("fs_spacing1", fs_last - fs_prev, FRAME_CLK);
    check("fs_count1", fs_cnt, 32'd2);
    en = 1'b0;
    next_pix();
    check("drain_run", {31'd0, running}, 32'd1);
    check("drain_h", {22'd0, hcount}, 32'd1);
    n = 0;
    while (!(hcount == 10'd15 && vcount == 10'd11) && n < 400) begin
      next_pix();
      n++;
    end
    check("drain_pixels", n, 32'd126);
    check("drain_last_run", {31'd0, running}, 32'd1);
    next_pix();
    check("drain_idle_run", {31'd0, running}, 32'd0);
    check("drain_idle_h", {22'd0, hcount}, 32'd0);
    check("drain_idle_v", {22'd0, vcount}, 32'd0);
    check("drain_idle_hb", {31'd0, HBlank}, 32'd1);
    check("drain_idle_vb", {31'd0, VBlank}, 32'd1);
    check("drain_idle_de", {31'd0, DE}, 32'd0);
    tick(100);
    check("drain_no_fs", fs_cnt, 32'd2);
    check("drain_stay_idle", {31'd0, running}, 32'd0);

    // Re-arm during drain: drop en at line 2, raise at line 5; frames continue unbroken.
    en = 1'b1;
    next_pix();
    check("rearm_start_fs", {31'd0, frame_start}, 32'd1);
    mon_run = 1'b1;
    repeat (2 * HT) next_pix();
    en = 1'b0;
    repeat (3 * HT) next_pix();
    check("rearm_v", {22'd0, vcount}, 32'd5);
    check("rearm_run", {31'd0, running}, 32'd1);
    en = 1'b1;
    n = 0;
    while (!(hcount == 10'd0 && vcount == 10'd0) && n < 400) begin
      next_pix();
      n++;
    end
    check("rearm_wrap_fs", {31'd0, frame_start}, 32'd1);
    tick();
    check("fs_spacing2", fs_last - fs_prev, FRAME_CLK);
    check("fs_count2", fs_cnt, 32'd4);
    check("rearm_no_drop", run_drops, 32'd0);
    mon_run = 1'b0;

    // Reset mid-frame at (10, 9), where HSync is active.
    n = 0;
    while (!(hcount == 10'd10 && vcount == 10'd9) && n < 400) begin
      next_pix();
      n++;
    end
    check("pre_reset_hs", {31'd0, HSync}, 32'd1);
    check("pre_reset_vb", {31'd0, VBlank}, 32'd1);
    reset_n = 1'b0;
    tick();
    check_reset_vals("midreset");
    reset_n = 1'b1;
    tick(2);
    check("post_reset_ce_early", {31'd0, ce_pix}, 32'd0);
    tick();
    check("post_reset_ce", {31'd0, ce_pix}, 32'd1);
    check("post_reset_idle", {31'd0, running}, 32'd0);
    tick();
    check("post_reset_fs", {31'd0, frame_start}, 32'd1);
    check("post_reset_run", {31'd0, running}, 32'd1);
    check("post_reset_de", {31'd0, DE}, 32'd1);
    check("post_reset_h", {22'd0, hcount}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
